// File: rtl/tx_cw_keyer.sv
// Morse CW keyer: queues dot/dash/char-space/word-space codes in a small
// FIFO and plays them out on tx_cw with standard Morse unit timing.
module tx_cw_keyer #(
  parameter int UNIT_TICKS = 2,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sym_valid,
  input  logic [1:0]                    sym_code,
  output logic                          sym_ready,
  output logic                          tx_cw,
  output logic                          busy,
  output logic                          sym_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(UNIT_TICKS - 1);
  localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(3 * UNIT_TICKS - 1);
  localparam logic [CNT_W-1:0] CHAR_LOAD = CNT_W'(2 * UNIT_TICKS - 1);
  localparam logic [CNT_W-1:0] WORD_LOAD = CNT_W'(6 * UNIT_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(UNIT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, MARK, GAP, SPACE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               tx_reg;
  logic [1:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]   level_reg;
  logic [1:0]         head_code;
  logic               push, pop, load;

  assign sym_ready  = (level_reg != LVL_FULL);
  assign push       = sym_valid && sym_ready;
  assign head_code  = fifo_mem[rd_ptr_reg];
  assign fifo_level = level_reg;
  assign tx_cw      = tx_reg;
  assign busy       = (state_reg != IDLE) || (level_reg != '0);
  // Last cycle of a symbol: the trailing gap or the space has run out.
  assign sym_done   = ((state_reg == GAP) || (state_reg == SPACE)) && (cnt_reg == '0);

  // Symbol storage; the head is read combinationally so a pop can load the
  // next element on the same edge the previous symbol finishes.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= sym_code;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_ONE;
        2'b01:   level_reg <= level_reg - LVL_ONE;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Next state: count down the current element, chain straight into the
  // next queued symbol when one finishes.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (level_reg != '0) load = 1'b1;
      end
      MARK: begin
        if (cnt_reg == '0) begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      GAP, SPACE: begin
        if (cnt_reg == '0) begin
          if (level_reg != '0) load = 1'b1;
          else                 state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) begin
      pop = 1'b1;
      case (head_code)
        2'd0:    begin state_next = MARK;  cnt_next = DOT_LOAD;  end
        2'd1:    begin state_next = MARK;  cnt_next = DASH_LOAD; end
        2'd2:    begin state_next = SPACE; cnt_next = CHAR_LOAD; end
        default: begin state_next = SPACE; cnt_next = WORD_LOAD; end
      endcase
    end
  end

  // State, counter and the registered key line (high exactly while in MARK).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      tx_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tx_reg    <= (state_next == MARK);
    end
  end

endmodule

// File: tb/tb_tx_cw_keyer.sv
// Directed bench for tx_cw_keyer (UNIT_TICKS = 2). Expected key waveforms are
// built from Morse unit lengths and compared cycle by cycle.
module tb_tx_cw_keyer;

  localparam int U = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sym_valid;
  logic [1:0] sym_code;
  logic       sym_ready, tx_cw, busy, sym_done;
  logic [2:0] fifo_level;

  int error_cnt = 0;
  int check_cnt = 0;

  logic [1:0] seq_code [16];
  int         seq_start [16];
  int         seq_n;

  tx_cw_keyer #(.UNIT_TICKS(U), .CNT_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_code(sym_code),
    .sym_ready(sym_ready), .tx_cw(tx_cw), .busy(busy), .sym_done(sym_done),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    check_cnt++;
    if (obs != exp) begin
      error_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add_sym(input logic [1:0] code, input int start);
    seq_code[seq_n]  = code;
    seq_start[seq_n] = start;
    seq_n++;
  endtask

  // Called at the start of cycle 0 (just after an edge). Cycle c is the
  // interval after edge c; the first symbol is presented in cycle 0.
  task automatic run_seq(input string name, input int probe_cyc,
                         input int probe_lvl, input int probe_rdy);
    bit exp_tx [$];
    bit exp_done [$];
    int len;
    int hi, lo;
    for (int s = 0; s < seq_n; s++) begin
      case (seq_code[s])
        2'd0:    begin hi = U;     lo = U;     end
        2'd1:    begin hi = 3 * U; lo = U;     end
        2'd2:    begin hi = 0;     lo = 2 * U; end
        default: begin hi = 0;     lo = 6 * U; end
      endcase
      for (int k = 0; k < hi; k++) begin exp_tx.push_back(1'b1); exp_done.push_back(1'b0); end
      for (int k = 0; k < lo; k++) begin exp_tx.push_back(1'b0); exp_done.push_back(k == lo - 1); end
    end
    len = exp_tx.size();
    fork
      begin
        int  i;
        int  cyc;
        logic acc;
        i = 0;
        cyc = 0;
        while (i < seq_n && cyc <= len + 2) begin
          if (cyc >= seq_start[i]) begin
            sym_valid = 1'b1;
            sym_code  = seq_code[i];
          end else begin
            sym_valid = 1'b0;
          end
          @(negedge clk);
          acc = sym_valid && sym_ready;
          next_cycle();
          cyc++;
          if (acc) i++;
        end
        sym_valid = 1'b0;
        check_val($sformatf("%s accepted", name), i, seq_n);
      end
      begin
        int etx, edn;
        for (int c = 0; c <= len + 2; c++) begin
          @(negedge clk);
          etx = (c >= 2 && c - 2 < len) ? int'(exp_tx[c-2]) : 0;
          edn = (c >= 2 && c - 2 < len) ? int'(exp_done[c-2]) : 0;
          check_val($sformatf("%s tx c%0d", name, c), int'(tx_cw), etx);
          check_val($sformatf("%s done c%0d", name, c), int'(sym_done), edn);
          if (c == 1) check_val($sformatf("%s busy c1", name), int'(busy), 1);
          if (c == probe_cyc) begin
            check_val($sformatf("%s level c%0d", name, c), int'(fifo_level), probe_lvl);
            check_val($sformatf("%s ready c%0d", name, c), int'(sym_ready), probe_rdy);
          end
          if (c == len + 2) begin
            check_val($sformatf("%s busy end", name), int'(busy), 0);
            check_val($sformatf("%s level end", name), int'(fifo_level), 0);
          end
        end
      end
    join
    $display("seq %s: %0d symbols, %0d cycles", name, seq_n, len);
    next_cycle();
    seq_n = 0;
  endtask

  initial begin
    int n_done, n_tx;
    rst = 1'b0;
    sym_valid = 1'b0;
    sym_code = 2'd0;
    seq_n = 0;
    repeat (3) next_cycle();
    @(negedge clk);
    check_val("reset tx", int'(tx_cw), 0);
    check_val("reset done", int'(sym_done), 0);
    check_val("reset busy", int'(busy), 0);
    check_val("reset ready", int'(sym_ready), 1);
    check_val("reset level", int'(fifo_level), 0);
    next_cycle();
    rst = 1'b1;
    repeat (2) next_cycle();

    add_sym(2'd0, 0);
    run_seq("dot", -1, 0, 0);

    add_sym(2'd1, 0); add_sym(2'd0, 0);
    run_seq("dash_dot", -1, 0, 0);

    add_sym(2'd0, 0); add_sym(2'd2, 0); add_sym(2'd1, 0);
    run_seq("dot_char_dash", -1, 0, 0);

    add_sym(2'd0, 0); add_sym(2'd3, 0); add_sym(2'd0, 0);
    run_seq("dot_word_dot", -1, 0, 0);

    for (int k = 0; k < 6; k++) add_sym(2'd1, 0);
    run_seq("six_dashes", 5, 4, 0);

    add_sym(2'd0, 0); add_sym(2'd0, 0); add_sym(2'd1, 0); add_sym(2'd0, 5);
    run_seq("push_on_pop", 6, 2, 1);

    add_sym(2'd0, 0); add_sym(2'd1, 0); add_sym(2'd2, 0); add_sym(2'd0, 0);
    add_sym(2'd3, 0); add_sym(2'd1, 0); add_sym(2'd0, 0); add_sym(2'd0, 0);
    add_sym(2'd2, 0); add_sym(2'd1, 0);
    run_seq("mixed10", 3, 2, 1);

    add_sym(2'd2, 0); add_sym(2'd0, 0);
    run_seq("lead_space", -1, 0, 0);

    // Reset in the middle of a dash mark, with two dots still queued.
    sym_valid = 1'b1;
    sym_code = 2'd1;
    next_cycle();
    sym_code = 2'd0;
    next_cycle();
    next_cycle();
    sym_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    check_val("abort tx before", int'(tx_cw), 1);
    check_val("abort level before", int'(fifo_level), 2);
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_val("abort tx", int'(tx_cw), 0);
    check_val("abort level", int'(fifo_level), 0);
    check_val("abort busy", int'(busy), 0);
    check_val("abort ready", int'(sym_ready), 1);
    n_done = 0;
    n_tx = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_done += int'(sym_done);
      n_tx += int'(tx_cw);
    end
    check_val("abort no done", n_done, 0);
    check_val("abort no tx", n_tx, 0);
    next_cycle();
    $display("seq abort: reset mid-dash");

    add_sym(2'd0, 0);
    run_seq("dot_after_abort", -1, 0, 0);

    $display("Result: errors=%0d of %0d checks", error_cnt, check_cnt);
    $finish;
  end

endmodule
